// File: rtl/warp_dispatcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | warp_dispatcher_pkg                                                      |
// | Shared kernel descriptor type and constants for the warp dispatcher.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package warp_dispatcher_pkg;

  localparam int NUM_SIMD_CORES    = 4;
  localparam int LOG2_THREAD_COUNT = 3;
  localparam logic [3:0] NO_WARP   = 4'b1111;

  typedef struct packed {
    logic [31:0]                  start_pc;
    logic [LOG2_THREAD_COUNT-1:0] thread_count;
    logic [3:0]                   warp_id;
  } kernel_t;

endpackage
`default_nettype wire

// File: rtl/circular_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | circular_buffer                                                          |
// | FIFO of SIZE entries (power of two) with show-ahead head on dout.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module circular_buffer #(
  parameter type T    = logic,
  parameter int  SIZE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int c_PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int c_CNT_W = $clog2(SIZE) + 1;

  T                   r_mem [SIZE];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_CNT_W'(SIZE));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Pointers wrap naturally because SIZE is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/warp_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | warp_dispatcher                                                          |
// | Queues kernel descriptors, launches them on the lowest idle SIMD core    |
// | and reports retired warp IDs. Optional watchdog: WARP_DISPATCHER_TIMEOUT_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module warp_dispatcher
  import warp_dispatcher_pkg::*;
#(
  parameter int NUM_SIMD_CORES    = warp_dispatcher_pkg::NUM_SIMD_CORES,
  parameter int LOG2_THREAD_COUNT = warp_dispatcher_pkg::LOG2_THREAD_COUNT,
  parameter int QUEUE_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               valid_kernel,
  input  kernel_t                                            kernel_in,
  output logic                                               kernel_ready,
  output logic                                               drop_err,
  output logic [NUM_SIMD_CORES-1:0]                          core_start,
  output logic [NUM_SIMD_CORES-1:0][31:0]                    core_pc,
  output logic [NUM_SIMD_CORES-1:0][LOG2_THREAD_COUNT-1:0]   core_thread_count,
  input  logic [NUM_SIMD_CORES-1:0]                          core_done,
  output logic [NUM_SIMD_CORES-1:0][3:0]                     finished_warp_id,
  output logic [NUM_SIMD_CORES-1:0]                          timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_RETIRE  = 2'd3
  } core_state_e;

`ifdef WARP_DISPATCHER_TIMEOUT_EN
  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

  kernel_t                   w_head;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_bad;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_found;
  logic [NUM_SIMD_CORES-1:0] w_idle;
  logic [NUM_SIMD_CORES-1:0] w_sel;
  logic                      r_drop_err;

  assign kernel_ready = !w_full;
  assign w_bad        = (kernel_in.thread_count == '0) || (kernel_in.warp_id == NO_WARP);
  assign w_push       = valid_kernel && kernel_ready && !w_bad;
  assign drop_err     = r_drop_err;

  circular_buffer #(
    .T    (kernel_t),
    .SIZE (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (kernel_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop_err <= 1'b0;
    else     r_drop_err <= valid_kernel && (!kernel_ready || w_bad);
  end

  // Priority encoder: the lowest-index idle core takes the queue head.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SIMD_CORES; i++) begin
      if (!w_found && w_idle[i] && !w_empty) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  assign w_pop = w_found;

  for (genvar i = 0; i < NUM_SIMD_CORES; i++) begin : g_core
    core_state_e                  r_state;
    core_state_e                  w_next;
    logic [3:0]                   r_warp_id;
    logic [31:0]                  r_pc;
    logic [LOG2_THREAD_COUNT-1:0] r_tc;
    logic                         r_start;
    logic [3:0]                   r_fin;
`ifdef WARP_DISPATCHER_TIMEOUT_EN
    logic [c_TMR_W-1:0]           r_timer;
    logic [c_TMR_W-1:0]           w_timer_inc;
    logic                         w_timeout;
    logic                         r_timeout_err;

    assign w_timer_inc = r_timer + c_TMR_W'(1);
`endif

    always_comb begin
      w_next = r_state;
`ifdef WARP_DISPATCHER_TIMEOUT_EN
      w_timeout = 1'b0;
`endif
      case (r_state)
        ST_IDLE:    if (w_sel[i]) w_next = ST_LAUNCH;
        ST_LAUNCH:  w_next = ST_RUNNING;
        ST_RUNNING: begin
          if (core_done[i]) begin
            w_next = ST_RETIRE;
          end
`ifdef WARP_DISPATCHER_TIMEOUT_EN
          else if (w_timer_inc == c_TMR_W'(TIMEOUT_CYCLES - 1)) begin
            w_next    = ST_RETIRE;
            w_timeout = 1'b1;
          end
`endif
        end
        ST_RETIRE:  w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end

    // Pulses are registered from the next state so they coincide with it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_warp_id <= NO_WARP;
        r_pc      <= '0;
        r_tc      <= '0;
        r_start   <= 1'b0;
        r_fin     <= NO_WARP;
      end else begin
        r_state <= w_next;
        r_start <= (w_next == ST_LAUNCH);
        r_fin   <= (w_next == ST_RETIRE) ? r_warp_id : NO_WARP;
        if (w_sel[i]) begin
          r_pc      <= w_head.start_pc;
          r_tc      <= w_head.thread_count;
          r_warp_id <= w_head.warp_id;
        end
      end
    end

`ifdef WARP_DISPATCHER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_timer       <= '0;
        r_timeout_err <= 1'b0;
      end else begin
        r_timeout_err <= w_timeout;
        if (r_state == ST_LAUNCH)       r_timer <= '0;
        else if (r_state == ST_RUNNING) r_timer <= w_timer_inc;
      end
    end

    assign timeout_err[i] = r_timeout_err;
`else
    assign timeout_err[i] = 1'b0;
`endif

    assign w_idle[i]            = (r_state == ST_IDLE);
    assign core_start[i]        = r_start;
    assign core_pc[i]           = r_pc;
    assign core_thread_count[i] = r_tc;
    assign finished_warp_id[i]  = r_fin;
  end

endmodule
`default_nettype wire

// File: tb/tb_warp_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_warp_dispatcher                                                       |
// | Directed, table-driven bench for warp_dispatcher.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_warp_dispatcher;
  import warp_dispatcher_pkg::*;

`ifdef WARP_DISPATCHER_TIMEOUT_EN
  localparam int c_TO = 8;
`else
  localparam int c_TO = 1024;
`endif
  localparam int c_NV = 38;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  tc;
    logic [3:0]  id;
    logic [3:0]  done;
    logic        exp_ready;
    logic        exp_drop;
    logic [3:0]  exp_start;
    logic [15:0] exp_fin;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            valid_kernel;
  kernel_t         kernel_in;
  logic            kernel_ready;
  logic            drop_err;
  logic [3:0]      core_start;
  logic [3:0][31:0] core_pc;
  logic [3:0][2:0] core_thread_count;
  logic [3:0]      core_done;
  logic [3:0][3:0] finished_warp_id;
  logic [3:0]      timeout_err;

  int n_pass;
  int n_total;
  vec_t vecs [c_NV];

  warp_dispatcher #(
    .NUM_SIMD_CORES    (4),
    .LOG2_THREAD_COUNT (3),
    .QUEUE_DEPTH       (4),
    .TIMEOUT_CYCLES    (c_TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_kernel      (valid_kernel),
    .kernel_in         (kernel_in),
    .kernel_ready      (kernel_ready),
    .drop_err          (drop_err),
    .core_start        (core_start),
    .core_pc           (core_pc),
    .core_thread_count (core_thread_count),
    .core_done         (core_done),
    .finished_warp_id  (finished_warp_id),
    .timeout_err       (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic [2:0] tc,
                               input logic [3:0] id, input logic [3:0] done, input logic rdy,
                               input logic drp, input logic [3:0] st, input logic [15:0] fin);
    vec_t r;
    r.valid = v; r.pc = pc; r.tc = tc; r.id = id; r.done = done;
    r.exp_ready = rdy; r.exp_drop = drp; r.exp_start = st; r.exp_fin = fin;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] tc,
                       input logic [3:0] id, input logic [3:0] done);
    valid_kernel = v;
    kernel_in    = '{start_pc: pc, thread_count: tc, warp_id: id};
    core_done    = done;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ready"}, 32'(kernel_ready), 32'd1);
    chk({tag, " drop"}, 32'(drop_err), 32'd0);
    chk({tag, " start"}, 32'(core_start), 32'd0);
    chk({tag, " pc0"}, core_pc[0], 32'd0);
    chk({tag, " pc1"}, core_pc[1], 32'd0);
    chk({tag, " tc"}, 32'(core_thread_count), 32'd0);
    chk({tag, " fin"}, 32'(finished_warp_id), 32'h0000FFFF);
    chk({tag, " timeout"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 4'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("in_reset");
    #2 rst = 1'b0;
    #1;
    chk_idle_outputs("after_reset");

`ifdef WARP_DISPATCHER_TIMEOUT_EN
    drive(1'b1, 32'h600, 3'd2, 4'd3, 4'h0);
    step();
    drive(1'b0, 32'h0, 3'd0, 4'd0, 4'h0);
    step();
    chk("to launch", 32'(core_start), 32'h1);
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("to wait%0d err", c), 32'(timeout_err), 32'h0);
      chk($sformatf("to wait%0d fin", c), 32'(finished_warp_id), 32'hFFFF);
    end
    step();
    chk("to fire err", 32'(timeout_err), 32'h1);
    chk("to fire fin", 32'(finished_warp_id), 32'hFFF3);
    step();
    chk("to clear err", 32'(timeout_err), 32'h0);
    chk("to clear fin", 32'(finished_warp_id), 32'hFFFF);
`else
    vecs[0]  = mkv(1, 32'h100, 3'd4, 4'd2,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[1]  = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h1, 16'hFFFF);
    vecs[2]  = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[3]  = mkv(0, 32'h0,   3'd0, 4'd0,  4'h1, 1, 0, 4'h0, 16'hFFF2);
    vecs[4]  = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[5]  = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[6]  = mkv(1, 32'h200, 3'd1, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[7]  = mkv(1, 32'h204, 3'd1, 4'd1,  4'h0, 1, 0, 4'h1, 16'hFFFF);
    vecs[8]  = mkv(1, 32'h208, 3'd1, 4'd2,  4'h0, 1, 0, 4'h2, 16'hFFFF);
    vecs[9]  = mkv(1, 32'h20C, 3'd1, 4'd3,  4'h0, 1, 0, 4'h4, 16'hFFFF);
    vecs[10] = mkv(1, 32'h210, 3'd1, 4'd4,  4'h0, 1, 0, 4'h8, 16'hFFFF);
    vecs[11] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[12] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h4, 1, 0, 4'h0, 16'hF2FF);
    vecs[13] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[14] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h4, 16'hFFFF);
    vecs[15] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[16] = mkv(1, 32'h314, 3'd2, 4'd5,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[17] = mkv(1, 32'h318, 3'd2, 4'd6,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[18] = mkv(1, 32'h31C, 3'd2, 4'd7,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[19] = mkv(1, 32'h320, 3'd2, 4'd8,  4'h0, 0, 0, 4'h0, 16'hFFFF);
    vecs[20] = mkv(1, 32'h324, 3'd2, 4'd9,  4'h0, 0, 1, 4'h0, 16'hFFFF);
    vecs[21] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 0, 0, 4'h0, 16'hFFFF);
    vecs[22] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h2, 0, 0, 4'h0, 16'hFF1F);
    vecs[23] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 0, 0, 4'h0, 16'hFFFF);
    vecs[24] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h2, 16'hFFFF);
    vecs[25] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h9, 1, 0, 4'h0, 16'h3FF0);
    vecs[26] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[27] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h1, 16'hFFFF);
    vecs[28] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h8, 16'hFFFF);
    vecs[29] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[30] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h9, 1, 0, 4'h0, 16'h7FF6);
    vecs[31] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[32] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h4, 1, 0, 4'h1, 16'hF4FF);
    vecs[33] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[34] = mkv(1, 32'h400, 3'd0, 4'd10, 4'h0, 1, 1, 4'h0, 16'hFFFF);
    vecs[35] = mkv(1, 32'h404, 3'd3, 4'd15, 4'h0, 1, 1, 4'h0, 16'hFFFF);
    vecs[36] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);
    vecs[37] = mkv(0, 32'h0,   3'd0, 4'd0,  4'h0, 1, 0, 4'h0, 16'hFFFF);

    for (int k = 0; k < c_NV; k++) begin
      drive(vecs[k].valid, vecs[k].pc, vecs[k].tc, vecs[k].id, vecs[k].done);
      step();
      chk($sformatf("v%0d ready", k), 32'(kernel_ready), 32'(vecs[k].exp_ready));
      chk($sformatf("v%0d drop", k), 32'(drop_err), 32'(vecs[k].exp_drop));
      chk($sformatf("v%0d start", k), 32'(core_start), 32'(vecs[k].exp_start));
      chk($sformatf("v%0d fin", k), 32'(finished_warp_id), 32'(vecs[k].exp_fin));
      if (k == 1) begin
        chk("v1 pc0", core_pc[0], 32'h100);
        chk("v1 tc0", 32'(core_thread_count[0]), 32'd4);
      end
      if (k == 14) begin
        chk("v14 pc2", core_pc[2], 32'h210);
        chk("v14 tc2", 32'(core_thread_count[2]), 32'd1);
      end
      if (k == 24) begin
        chk("v24 pc1", core_pc[1], 32'h314);
        chk("v24 tc1", 32'(core_thread_count[1]), 32'd2);
      end
      if (k == 32) chk("v32 pc0", core_pc[0], 32'h320);
    end

    // Cores 0 and 1 are running; launch one more on core 2, then reset mid-flight.
    drive(1'b1, 32'h440, 3'd5, 4'd11, 4'h0);
    step();
    drive(1'b0, 32'h0, 3'd0, 4'd0, 4'h0);
    step();
    chk("pre_rst start", 32'(core_start), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    core_done = 4'h3;
    step();
    step();
    chk("rst_hold fin", 32'(finished_warp_id), 32'hFFFF);
    core_done = 4'h0;
    #2 rst = 1'b0;
    step();
    chk("post_rst fin", 32'(finished_warp_id), 32'hFFFF);
    chk("post_rst start", 32'(core_start), 32'h0);
    core_done = 4'h3;
    step();
    chk("stale_done fin", 32'(finished_warp_id), 32'hFFFF);
    drive(1'b1, 32'h500, 3'd7, 4'd9, 4'h0);
    step();
    drive(1'b0, 32'h0, 3'd0, 4'd0, 4'h0);
    step();
    chk("relaunch start", 32'(core_start), 32'h1);
    chk("relaunch pc0", core_pc[0], 32'h500);
    chk("relaunch tc0", 32'(core_thread_count[0]), 32'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/warp_dispatcher.md
# warp_dispatcher

Receiving end of the scheduler-to-core kernel interface. Accepts `kernel_t` descriptors (start PC, thread count, warp ID) from the warp scheduler and queues them. It launches each one on the lowest-indexed idle SIMD core, tracks execution until the core reports completion, then returns the warp ID on `finished_warp_id` so the scheduler can recycle it. Sits between the warp scheduler and the SIMD core array.

## Interface
- `NUM_SIMD_CORES`, default 4: number of SIMD cores served.
- `LOG2_THREAD_COUNT`, default 3: width of the thread-count field.
- `QUEUE_DEPTH`, default 4: kernel queue entries, power of two.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only when `WARP_DISPATCHER_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `valid_kernel` in 1: descriptor valid on `kernel_in`.
- `kernel_in` in `kernel_t`: `{start_pc[31:0], thread_count[LOG2_THREAD_COUNT-1:0], warp_id[3:0]}`.
- `kernel_ready` out 1: queue can accept this cycle.
- `drop_err` out 1: one-cycle pulse when a descriptor is discarded.
- `core_start` out [NUM_SIMD_CORES] x 1: one-cycle launch pulse per core.
- `core_pc` out [NUM_SIMD_CORES] x 32: start PC, held while the core is busy.
- `core_thread_count` out [NUM_SIMD_CORES] x LOG2_THREAD_COUNT: held while busy.
- `core_done` in [NUM_SIMD_CORES] x 1: core finished its warp.
- `finished_warp_id` out [NUM_SIMD_CORES] x 4: retired warp ID for one cycle, else 4'b1111.
- `timeout_err` out [NUM_SIMD_CORES] x 1: watchdog retire pulse. Tied 0 without the macro.

## Operation
- **Accept.** A descriptor is accepted on the edge where `valid_kernel && kernel_ready`. `kernel_ready = !queue_full`.
- **Discard.** `drop_err` pulses and the descriptor is discarded, with no enqueue, in either of these cases:
  - `valid_kernel && !kernel_ready`;
  - an accepted descriptor with `thread_count == 0` or `warp_id == 4'b1111`.
- **Per-core FSM.** States are IDLE, LAUNCH, RUNNING, RETIRE.
  - IDLE -> LAUNCH: the core is selected for dispatch. The queue head is popped and its fields latched into `core_pc`, `core_thread_count` and an internal `warp_id`.
  - LAUNCH -> RUNNING: unconditional. `core_start = 1` only in LAUNCH.
  - RUNNING -> RETIRE: on `core_done`. `core_done` is ignored in every other state.
  - RETIRE -> IDLE: unconditional. `finished_warp_id = warp_id` only in RETIRE.
- **Dispatch.** At most one dispatch per cycle. The queue must be non-empty, and the target is the lowest-index core in IDLE. A core entering IDLE from RETIRE at edge E is eligible in the cycle after E.
- **Simultaneous events.**
  - Push and pop in the same cycle are allowed when the queue is not full. The occupancy is unchanged.
  - A dispatch and a retire on different cores in the same cycle are independent.
- **Queue.** FIFO order. Pointers wrap modulo QUEUE_DEPTH. A full/empty distinction is kept with an occupancy counter of width log2(QUEUE_DEPTH)+1.

## Timing
- **Reset values.** `kernel_ready = 1`, `drop_err = 0`, all `core_start = 0`, `core_pc = 0`, `core_thread_count = 0`, all `finished_warp_id = 4'b1111`, `timeout_err = 0`. Queue empty, all FSMs in IDLE.
- **Reset mid-operation.** Asserting `rst` mid-operation aborts in-flight warps silently, with no `finished_warp_id` report.
- **Launch latency.** A descriptor accepted at edge E0 into an empty queue with core 0 idle gives `core_start[0]` high from E1 to E2.
- **Retire latency.** `core_done` sampled high at edge Ed gives `finished_warp_id` valid from Ed to Ed+1.
- **Registered outputs.** All outputs are registered except `kernel_ready`, which is derived combinationally from the registered occupancy.

## Configuration
- **`WARP_DISPATCHER_TIMEOUT_EN` defined.** Each core has a cycle counter that clears on LAUNCH and counts in RUNNING. On reaching TIMEOUT_CYCLES-1 without `core_done`, the core goes to RETIRE and pulses `timeout_err[i]` together with `finished_warp_id[i]`.
- **Macro undefined.** There are no counters, `timeout_err` is constant 0, and RUNNING waits indefinitely.

## Structure
- **Shared package.** `kernel_t`, NUM_SIMD_CORES, LOG2_THREAD_COUNT and the constant `NO_WARP = 4'b1111` belong in the shared parameter/struct package.
- **Local types.** The core state enum is local to the module.
- **Sub-module.** The queue is the existing `circular_buffer`, instantiated with `T = kernel_t` and size QUEUE_DEPTH. Dispatch selection is a priority encoder over the IDLE flags, inline.

## Test plan
- **Single launch.** Reset, then one descriptor {pc 0x100, tc 4, id 2} -> `core_start[0]` one cycle later, with `core_pc[0] = 0x100` and `core_thread_count[0] = 4`. Then `core_done[0]` -> `finished_warp_id[0] = 2` for exactly one cycle, then 4'b1111.
- **Fill.** 5 back-to-back descriptors ids 0-4 with all `core_done` low -> cores 0-3 get ids 0-3 in order on consecutive cycles, and id 4 stays queued. `core_done[2]` -> id 4 launches on core 2.
- **Overflow.** Hold 4 cores busy and push 5 descriptors -> `kernel_ready = 0` after the 4th, and the 5th pulses `drop_err`. The queue contents are unchanged.
- **Invalid descriptors.** `thread_count = 0` or `warp_id = 4'b1111` -> `drop_err` pulses and no `core_start` follows.
- **Reset mid-operation.** Assert `rst` while cores 0 and 1 are RUNNING -> all outputs return to reset values asynchronously, and no retire is reported.
- **Timeout (macro on, TIMEOUT_CYCLES=8).** No `core_done` -> `timeout_err[0]` and `finished_warp_id[0]` pulse 8 cycles after launch.
